// File: rtl/cochlea_ctrl_pkg.sv
// Shared definitions for the analog core sequencer.
// Holds the FSM state encoding and the default word width / synchronizer depth.
package cochlea_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_W           = 8;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_sync.sv
// Single-bit flop synchronizer for an asynchronous input.
// Ports: clk/rst_n (async active-low), d = asynchronous input,
//        q = synchronized output after STAGES clk edges.
module cdc_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/analog_core_seq.sv
// Digital sequencer for the cochlea analog core.
// Generates cclk/div2/lo drive clocks from clk, discards a warm-up period,
// then captures comparator decisions (high_buf) on each phi1b_dig strobe,
// feeds each bit back on fb1 and packs W bits LSB-first into data.
// Ports:
//   clk, rst_n           core clock, async active-low reset
//   en                   run request
//   cfg_cclk_div/lo_div/warmup  run configuration, latched on start
//   phi1b_dig, high_buf  asynchronous strobe / decision from the core
//   cclk, div2, lo, fb1  drives to the analog core
//   data, valid, ready   word handshake
//   ovf, clr_ovf         sticky overflow flag and its clear
//   state                current FSM state
module analog_core_seq
  import cochlea_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int unsigned W           = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [7:0]   cfg_cclk_div,
  input  logic [7:0]   cfg_lo_div,
  input  logic [7:0]   cfg_warmup,
  input  logic         phi1b_dig,
  input  logic         high_buf,
  output logic         cclk,
  output logic         div2,
  output logic         lo,
  output logic         fb1,
  output logic [W-1:0] data,
  output logic         valid,
  input  logic         ready,
  output logic         ovf,
  input  logic         clr_ovf,
  output logic [1:0]   state
);

  localparam int unsigned CW = $clog2(W + 1);

  state_t         state_q;
  logic [7:0]     cclk_div_q;
  logic [7:0]     lo_div_q;
  logic [7:0]     warmup_q;
  logic [7:0]     div_cnt;
  logic [7:0]     lo_cnt;
  logic [7:0]     warm_cnt;
  logic [W-1:0]   shreg;
  logic [CW-1:0]  bit_cnt;

  logic           phi_s;
  logic           hb_s;
  logic           phi_d;
  logic           strobe_q;
  logic           hb_q;

  logic           active;
  logic           cclk_rise;
  logic           strobe_run;
  logic           word_done;
  logic [W-1:0]   word;

  cdc_sync #(.STAGES(SYNC_STAGES)) u_sync_phi (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (phi1b_dig),
    .q     (phi_s)
  );

  cdc_sync #(.STAGES(SYNC_STAGES)) u_sync_hb (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (high_buf),
    .q     (hb_s)
  );

  // Edge detect is registered and high_buf is delayed alongside it, so the
  // decision used for a strobe is the one synchronized with that strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phi_d    <= 1'b0;
      strobe_q <= 1'b0;
      hb_q     <= 1'b0;
    end else begin
      phi_d    <= phi_s;
      strobe_q <= phi_s & ~phi_d;
      hb_q     <= hb_s;
    end
  end

  always_comb begin
    active     = ((state_q == WARMUP) || (state_q == RUN)) && en;
    cclk_rise  = active && (div_cnt == cclk_div_q) && !cclk;
    strobe_run = (state_q == RUN) && en && strobe_q;
    word_done  = strobe_run && (bit_cnt == CW'(W - 1));
    word       = {hb_q, shreg[W-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cclk_div_q <= '0;
      lo_div_q   <= '0;
      warmup_q   <= '0;
      div_cnt    <= '0;
      lo_cnt     <= '0;
      warm_cnt   <= '0;
      cclk       <= 1'b0;
      div2       <= 1'b0;
      lo         <= 1'b0;
      fb1        <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      data       <= '0;
      valid      <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            cclk_div_q <= cfg_cclk_div;
            lo_div_q   <= cfg_lo_div;
            warmup_q   <= cfg_warmup;
            state_q    <= (cfg_warmup == '0) ? RUN : WARMUP;
          end
        end
        WARMUP: begin
          if (!en) begin
            state_q <= IDLE;
          end else if (cclk_rise && ((warm_cnt + 8'd1) == warmup_q)) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (!en) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Anything that is not an enabled WARMUP/RUN cycle parks the drives and
      // discards any partial word; this also covers the exit to IDLE.
      if (!active) begin
        div_cnt  <= '0;
        lo_cnt   <= '0;
        warm_cnt <= '0;
        cclk     <= 1'b0;
        div2     <= 1'b0;
        lo       <= 1'b0;
        fb1      <= 1'b0;
        shreg    <= '0;
        bit_cnt  <= '0;
      end else begin
        if (div_cnt == cclk_div_q) begin
          div_cnt <= '0;
          cclk    <= ~cclk;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end

        if (cclk_rise) begin
          div2 <= ~div2;
          if (lo_cnt == lo_div_q) begin
            lo_cnt <= '0;
            lo     <= ~lo;
          end else begin
            lo_cnt <= lo_cnt + 8'd1;
          end
          if (state_q == WARMUP) begin
            warm_cnt <= warm_cnt + 8'd1;
          end
        end

        if (strobe_run) begin
          fb1   <= hb_q;
          shreg <= word;
          if (word_done) begin
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
      end

      // Output word register is independent of the FSM so a pending word
      // survives a stop until it is accepted.
      if (word_done && (!valid || ready)) begin
        data  <= word;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      if (word_done && valid && !ready) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_analog_core_seq.sv
module tb_analog_core_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] cfg_cclk_div;
  logic [7:0] cfg_lo_div;
  logic [7:0] cfg_warmup;
  logic       phi1b_dig;
  logic       high_buf;
  logic       cclk;
  logic       div2;
  logic       lo;
  logic       fb1;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       ovf;
  logic       clr_ovf;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;

  // captured by send_bit
  logic       fb_pre, fb_post, v_post, v_after, ovf_post;
  logic [7:0] d_post;

  int unsigned rise_cnt = 0;
  int unsigned rise_base;

  typedef struct {
    logic [7:0] cdiv;
    logic [7:0] ldiv;
    int         cp;
    int         dp;
    int         lp;
  } per_vec_t;

  typedef struct {
    logic       hb;
    logic       fpre;
    logic       fpost;
    logic       vpost;
    logic [7:0] dexp;
  } bit_vec_t;

  per_vec_t pv[4];
  bit_vec_t bv[8];

  int   c0, c1, d0, d1, l0, l1;
  logic pc, pd, pl;
  logic early;
  logic found;

  analog_core_seq #(.SYNC_STAGES(2), .W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .cfg_cclk_div (cfg_cclk_div),
    .cfg_lo_div   (cfg_lo_div),
    .cfg_warmup   (cfg_warmup),
    .phi1b_dig    (phi1b_dig),
    .high_buf     (high_buf),
    .cclk         (cclk),
    .div2         (div2),
    .lo           (lo),
    .fb1          (fb1),
    .data         (data),
    .valid        (valid),
    .ready        (ready),
    .ovf          (ovf),
    .clr_ovf      (clr_ovf),
    .state        (state)
  );

  always #5 clk = ~clk;

  always @(posedge cclk) rise_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge. Edge e1 samples the strobe; fb1 must change at e4.
  task automatic send_bit(input logic hb, input logic clr_at_done);
    phi1b_dig = 1'b1;
    high_buf  = hb;
    cyc(3);
    fb_pre  = fb1;
    clr_ovf = clr_at_done;
    cyc(1);
    fb_post  = fb1;
    v_post   = valid;
    d_post   = data;
    ovf_post = ovf;
    clr_ovf  = 1'b0;
    phi1b_dig = 1'b0;
    cyc(1);
    v_after = valid;
    cyc(1);
  endtask

  task automatic send_word(input logic [7:0] w, input logic clr_last, output logic early_v);
    early_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i], clr_last && (i == 7));
      if (i < 7 && v_post) early_v = 1'b1;
    end
  endtask

  task automatic start(input logic [7:0] cd, input logic [7:0] ld, input logic [7:0] wu);
    en = 1'b0;
    cyc(2);
    cfg_cclk_div = cd;
    cfg_lo_div   = ld;
    cfg_warmup   = wu;
    en = 1'b1;
    cyc(1);
  endtask

  initial begin
    pv[0] = '{8'd1, 8'd2, 4, 8, 24};
    pv[1] = '{8'd0, 8'd0, 2, 4, 4};
    pv[2] = '{8'd2, 8'd1, 6, 12, 24};
    pv[3] = '{8'd3, 8'd0, 8, 16, 16};

    // 1,0,1,1,0,0,0,1 LSB-first -> 8'h8D
    bv[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    bv[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    bv[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    bv[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    bv[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    bv[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    bv[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    bv[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h8D};

    rst_n = 1'b0; en = 1'b0; ready = 1'b0; clr_ovf = 1'b0;
    phi1b_dig = 1'b0; high_buf = 1'b0;
    cfg_cclk_div = 8'd0; cfg_lo_div = 8'd0; cfg_warmup = 8'd0;
    cyc(2);
    check("reset_state", {30'd0, state}, 0);
    check("reset_drives", {28'd0, cclk, div2, lo, fb1}, 0);
    check("reset_data", {24'd0, data}, 0);
    check("reset_flags", {30'd0, valid, ovf}, 0);
    rst_n = 1'b1;
    cyc(2);
    check("idle_after_reset", {30'd0, state}, 0);

    // Clock generation; cfg changed after start must be ignored.
    for (int r = 0; r < 4; r++) begin
      start(pv[r].cdiv, pv[r].ldiv, 8'd0);
      check("run_one_clk_after_en", {30'd0, state}, 2);
      cfg_cclk_div = pv[r].cdiv + 8'd5;
      cfg_lo_div   = pv[r].ldiv + 8'd3;
      pc = cclk; pd = div2; pl = lo;
      c0 = -1; c1 = -1; d0 = -1; d1 = -1; l0 = -1; l1 = -1;
      for (int n = 0; n < 100; n++) begin
        cyc(1);
        if (cclk && !pc) begin if (c0 < 0) c0 = n; else if (c1 < 0) c1 = n; end
        if (div2 && !pd) begin if (d0 < 0) d0 = n; else if (d1 < 0) d1 = n; end
        if (lo && !pl)   begin if (l0 < 0) l0 = n; else if (l1 < 0) l1 = n; end
        pc = cclk; pd = div2; pl = lo;
      end
      check("cclk_period", (c1 >= 0) ? c1 - c0 : -1, pv[r].cp);
      check("div2_period", (d1 >= 0) ? d1 - d0 : -1, pv[r].dp);
      check("lo_period",   (l1 >= 0) ? l1 - l0 : -1, pv[r].lp);
      en = 1'b0;
      cyc(2);
      check("idle_drives_zero", {28'd0, cclk, div2, lo, fb1}, 0);
    end

    // Warm-up: strobes ignored, RUN on the 3rd cclk rise.
    ready = 1'b1;
    rise_base = rise_cnt;
    start(8'd15, 8'd2, 8'd3);
    check("warmup_entered", {30'd0, state}, 1);
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
    check("warmup_fb1", {31'd0, fb1}, 0);
    check("warmup_no_valid", {31'd0, valid}, 0);
    check("warmup_still", {30'd0, state}, 1);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      cyc(1);
      if (state == 2'd2) found = 1'b1;
    end
    check("warmup_to_run", {31'd0, found}, 1);
    check("warmup_rises", rise_cnt - rise_base, 3);
    check("warmup_cclk_at_run", {31'd0, cclk}, 1);

    // Word assembly with fb1 latency.
    start(8'd1, 8'd2, 8'd0);
    for (int i = 0; i < 8; i++) begin
      send_bit(bv[i].hb, 1'b0);
      check("fb1_before", {31'd0, fb_pre}, {31'd0, bv[i].fpre});
      check("fb1_after", {31'd0, fb_post}, {31'd0, bv[i].fpost});
      check("valid_at_bit", {31'd0, v_post}, {31'd0, bv[i].vpost});
      if (bv[i].vpost) begin
        check("word_data", {24'd0, d_post}, {24'd0, bv[i].dexp});
        check("valid_one_cycle", {31'd0, v_after}, 0);
      end
    end

    // Backpressure and overflow.
    ready = 1'b0;
    start(8'd1, 8'd2, 8'd0);
    send_word(8'hA5, 1'b0, early);
    check("ovf_w1_valid", {31'd0, v_post}, 1);
    check("ovf_w1_data", {24'd0, d_post}, 32'hA5);
    check("ovf_w1_flag", {31'd0, ovf_post}, 0);
    send_word(8'h3C, 1'b0, early);
    check("ovf_w2_held", {24'd0, d_post}, 32'hA5);
    check("ovf_w2_flag", {31'd0, ovf_post}, 1);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    check("clr_ovf", {31'd0, ovf}, 0);
    send_word(8'hC3, 1'b1, early);
    check("ovf_beats_clr", {31'd0, ovf_post}, 1);
    check("ovf_w3_held", {24'd0, d_post}, 32'hA5);
    en = 1'b0;
    cyc(2);
    check("pending_idle_state", {30'd0, state}, 0);
    check("pending_valid", {31'd0, valid}, 1);
    check("pending_data", {24'd0, data}, 32'hA5);
    ready = 1'b1;
    cyc(1);
    check("pending_accept", {31'd0, valid}, 0);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;

    // Stop after a partial word discards it.
    start(8'd1, 8'd2, 8'd0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    en = 1'b0;
    cyc(1);
    check("stop_to_idle", {30'd0, state}, 0);
    check("stop_drives_zero", {28'd0, cclk, div2, lo, fb1}, 0);
    en = 1'b1;
    cyc(1);
    check("restart_run", {30'd0, state}, 2);
    send_word(8'h42, 1'b0, early);
    check("no_stale_word", {31'd0, early}, 0);
    check("new_word_valid", {31'd0, v_post}, 1);
    check("new_word_data", {24'd0, d_post}, 32'h42);

    // Asynchronous reset mid-RUN with a pending word.
    ready = 1'b0;
    send_word(8'h99, 1'b0, early);
    check("pre_reset_valid", {31'd0, valid}, 1);
    check("pre_reset_fb1", {31'd0, fb1}, 1);
    #3 rst_n = 1'b0;
    #1;
    check("areset_state", {30'd0, state}, 0);
    check("areset_drives", {28'd0, cclk, div2, lo, fb1}, 0);
    check("areset_data", {22'd0, data, valid, ovf}, 0);
    en = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(3);
    check("post_reset_idle", {30'd0, state}, 0);
    check("post_reset_cclk", {31'd0, cclk}, 0);
    en = 1'b1;
    cyc(1);
    check("post_reset_start", {30'd0, state}, 2);
    en = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/analog_core_seq.md
ANALOG_CORE_SEQ -- requirements
Module: analog_core_seq

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for the asynchronous inputs phi1b_dig and high_buf.
REQ-002 The block SHALL have parameter W, default 8: output word width in comparator bits.
REQ-003 The block SHALL have port clk, input, 1: single digital core clock (vccd1 domain).
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1: run request (1 = start/continue, 0 = stop).
REQ-006 The block SHALL have port cfg_cclk_div, input, 8: cclk half-period minus 1, in clk cycles.
REQ-007 The block SHALL have port cfg_lo_div, input, 8: lo half-period minus 1, in cclk rising edges.
REQ-008 The block SHALL have port cfg_warmup, input, 8: number of cclk rising edges to discard after start.
REQ-009 The block SHALL have port phi1b_dig, input, 1: asynchronous sample strobe from the analog core.
REQ-010 The block SHALL have port high_buf, input, 1: asynchronous comparator decision from the analog core.
REQ-011 The block SHALL have outputs cclk, div2, lo and fb1, each 1 bit: drives to the analog core.
REQ-012 The block SHALL have port data, output, W: packed comparator bits.
REQ-013 The block SHALL have ports valid (output, 1) and ready (input, 1): data handshake.
REQ-014 The block SHALL have port ovf, output, 1: sticky overflow flag.
REQ-015 The block SHALL have port clr_ovf, input, 1: clears ovf.
REQ-016 The block SHALL have port state, output, 2: current FSM state.

Function
REQ-017 The FSM SHALL have states IDLE=0, WARMUP=1 and RUN=2; encoding 3 SHALL be unreachable and SHALL recover to IDLE.
REQ-018 IDLE, en=1: cfg_* latched, next state WARMUP, or RUN if cfg_warmup=0; cfg changes while not IDLE SHALL be ignored.
REQ-019 en=0 in WARMUP or RUN SHALL return the FSM to IDLE on the next clk, clearing the dividers, shift register and bit count (partial word discarded).
REQ-020 In IDLE, cclk, div2, lo and fb1 SHALL all be 0.
REQ-021 In WARMUP/RUN, cclk SHALL toggle when a divider counter reaches the latched cclk_div (counter then reset to 0), giving period 2*(cfg_cclk_div+1) clk cycles; the first toggle is 0->1.
REQ-022 div2 SHALL toggle on every cclk 0->1 transition.
REQ-023 lo SHALL toggle on every (cfg_lo_div+1)th cclk 0->1 transition.
REQ-024 WARMUP SHALL count cclk 0->1 transitions and enter RUN on the cycle the count reaches cfg_warmup; fb1 SHALL be held at 0 and strobes ignored during WARMUP.
REQ-025 phi1b_dig and high_buf SHALL each pass through a SYNC_STAGES flop synchronizer, and a rising edge of the synchronized phi1b_dig SHALL be detected with one further flop.
REQ-026 On each detected strobe in RUN, fb1 and the LSB-first shift register SHALL load synchronized high_buf, and the bit count SHALL increment.
REQ-027 fb1 SHALL update exactly SYNC_STAGES+1 clk edges after the first clk edge that samples phi1b_dig high.
REQ-028 On the Wth bit, the assembled word SHALL load data with valid=1 if valid=0 or (valid&ready) in that cycle; otherwise the word SHALL be dropped and ovf set; the bit count SHALL wrap to 0 either way.
REQ-029 valid SHALL remain 1 with data stable until valid&ready; ready with valid=0 SHALL have no effect.
REQ-030 A pending valid word SHALL survive a return to IDLE until accepted.
REQ-031 clr_ovf SHALL clear ovf, except that an overflow in the same cycle SHALL take priority and leave ovf=1.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state=IDLE, cclk=div2=lo=fb1=0, data=0, valid=0, ovf=0, all counters and synchronizer flops 0.
REQ-033 Deassertion of rst_n mid-operation SHALL resume in IDLE and require an en to start.

Structure
REQ-034 Package cochlea_ctrl_pkg SHALL hold the state enum (IDLE/WARMUP/RUN) and the default W and SYNC_STAGES constants.
REQ-035 One sub-module, cdc_sync (parameterized depth, 1 bit), SHALL be instantiated twice, for phi1b_dig and high_buf.

Verification
REQ-036 The bench SHALL cover: cfg_cclk_div=1, cfg_lo_div=2, cfg_warmup=0, en=1 -> cclk period 4 clk, div2 period 8 clk, lo period 24 clk, state=RUN one clk after en.
REQ-037 The bench SHALL cover: cfg_warmup=3, 8 strobes during WARMUP -> fb1=0, no valid; RUN entered on the 3rd cclk rise.
REQ-038 The bench SHALL cover: RUN, ready=1, 8 strobes with high_buf=1,0,1,1,0,0,0,1 -> data=8'h8D, valid for 1 cycle, fb1 tracking each bit at SYNC_STAGES+1 latency.
REQ-039 The bench SHALL cover: ready=0, 16 strobes -> first word held, second dropped, ovf=1; clr_ovf coincident with a 3rd-word overflow -> ovf stays 1.
REQ-040 The bench SHALL cover: en=0 after 5 bits, then en=1 and 8 bits -> only the new 8-bit word is emitted.
REQ-041 The bench SHALL cover: rst_n pulsed low mid-RUN with valid=1 -> all outputs 0 immediately, state=IDLE.
